// File: rtl/loba_mult_seq_if.sv
// Request/result stream bundle for loba_mult_seq; master drives requests, slave is the multiplier.
// The sgn field exists only when LOBA_SIGNED_EN is defined.
interface loba_mult_seq_if #(
  parameter int NA = 16,
  parameter int NB = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [NA-1:0]     a;
  logic [NB-1:0]     b;
  logic [1:0]        mode;
`ifdef LOBA_SIGNED_EN
  logic              sgn;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [NA+NB-1:0]  r;

  modport master (
`ifdef LOBA_SIGNED_EN
    output sgn,
`endif
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, r
  );

  modport slave (
`ifdef LOBA_SIGNED_EN
    input  sgn,
`endif
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, r
  );
endinterface

// File: rtl/loba_mult_seq.sv
// Sequential LOBA approximate multiplier: one KxK leading-one segment product per cycle into an accumulator.
// Optional feature macro LOBA_SIGNED_EN adds two's-complement operands selected per request by sgn.
module loba_mult_seq #(
  parameter int K  = 4,
  parameter int NA = 16,
  parameter int NB = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  loba_mult_seq_if.slave   bus
);
  localparam int NR = NA + NB;
  localparam int NM = (NA > NB) ? NA : NB;
  localparam int KW = $clog2(NM);
  localparam int SW = KW + 1;

  // IDLE wait for request | SPLIT magnitudes and segments | ACC one term per cycle | DONE hold result
  typedef enum logic [1:0] {IDLE, SPLIT, ACC, DONE} state_e;

  state_e          state_q, state_d;
  logic [NA-1:0]   a_q;
  logic [NB-1:0]   b_q;
  logic [1:0]      mode_q;
  logic            sgn_q;
  logic [1:0]      cnt_q;
  logic [K-1:0]    xah_q, xal_q, xbh_q, xbl_q;
  logic [KW-1:0]   kah_q, kal_q, kbh_q, kbl_q;
  logic [NR-1:0]   acc_q;
  logic [NR-1:0]   r_q;

  function automatic logic [KW-1:0] lead_idx(input logic [NM-1:0] x);
    lead_idx = KW'(K - 1);
    for (int i = K; i < NM; i++) begin
      if (x[i]) lead_idx = KW'(i);
    end
  endfunction

  function automatic logic [K-1:0] seg_val(input logic [NM-1:0] x, input logic [KW-1:0] k);
    logic [NM-1:0] sh;
    sh = x >> (k - KW'(K - 1));
    return sh[K-1:0];
  endfunction

  function automatic logic [NM-1:0] seg_rem(input logic [NM-1:0] x, input logic [KW-1:0] k);
    logic [NM-1:0] mask;
    mask = (NM'(1) << (k - KW'(K - 1))) - NM'(1);
    return x & mask;
  endfunction

  logic            neg;
  logic [NA-1:0]   mag_a;
  logic [NB-1:0]   mag_b;
  logic [NM-1:0]   ext_a, ext_b, rem_a, rem_b;
  logic [KW-1:0]   kah_d, kal_d, kbh_d, kbl_d;
  logic [K-1:0]    xah_d, xal_d, xbh_d, xbl_d;

  always_comb begin
    neg   = sgn_q & (a_q[NA-1] ^ b_q[NB-1]);
    mag_a = (sgn_q && a_q[NA-1]) ? -a_q : a_q;
    mag_b = (sgn_q && b_q[NB-1]) ? -b_q : b_q;
    ext_a = NM'(mag_a);
    ext_b = NM'(mag_b);
    kah_d = lead_idx(ext_a);
    xah_d = seg_val(ext_a, kah_d);
    rem_a = seg_rem(ext_a, kah_d);
    kal_d = lead_idx(rem_a);
    xal_d = seg_val(rem_a, kal_d);
    kbh_d = lead_idx(ext_b);
    xbh_d = seg_val(ext_b, kbh_d);
    rem_b = seg_rem(ext_b, kbh_d);
    kbl_d = lead_idx(rem_b);
    xbl_d = seg_val(rem_b, kbl_d);
  end

  // cnt_q counts down the remaining terms; idx walks HH, HL, LH, LL
  logic [1:0]      idx;
  logic [K-1:0]    xa, xb;
  logic [KW-1:0]   ka, kb;
  logic [2*K-1:0]  prod;
  logic [SW-1:0]   shamt;
  logic [NR-1:0]   term, sum;

  always_comb begin
    idx = mode_q - cnt_q;
    xa  = xah_q;
    ka  = kah_q;
    xb  = xbh_q;
    kb  = kbh_q;
    case (idx)
      2'd1:    begin xb = xbl_q; kb = kbl_q; end
      2'd2:    begin xa = xal_q; ka = kal_q; end
      2'd3:    begin xa = xal_q; ka = kal_q; xb = xbl_q; kb = kbl_q; end
      default: ;
    endcase
    prod  = {{K{1'b0}}, xa} * {{K{1'b0}}, xb};
    shamt = SW'(ka) + SW'(kb) - SW'(2 * (K - 1));
    term  = NR'(prod) << shamt;
    sum   = acc_q + term;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = SPLIT;
      SPLIT:   state_d = ACC;
      ACC:     if (cnt_q == 2'd0) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      IDLE:    bus.in_ready  = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.r = r_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
      sgn_q  <= 1'b0;
      cnt_q  <= '0;
      xah_q  <= '0;
      xal_q  <= '0;
      xbh_q  <= '0;
      xbl_q  <= '0;
      kah_q  <= '0;
      kal_q  <= '0;
      kbh_q  <= '0;
      kbl_q  <= '0;
      acc_q  <= '0;
      r_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            mode_q <= bus.mode;
`ifdef LOBA_SIGNED_EN
            sgn_q  <= bus.sgn;
`else
            sgn_q  <= 1'b0;
`endif
            acc_q  <= '0;
          end
        end
        SPLIT: begin
          xah_q <= xah_d;
          kah_q <= kah_d;
          xal_q <= xal_d;
          kal_q <= kal_d;
          xbh_q <= xbh_d;
          kbh_q <= kbh_d;
          xbl_q <= xbl_d;
          kbl_q <= kbl_d;
          cnt_q <= mode_q;
        end
        ACC: begin
          acc_q <= sum;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == 2'd0) r_q <= neg ? -sum : sum;
        end
        default: ;
      endcase
    end
  end
endmodule
